instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the main decoder. It accepts encode requests (instruction class plus fields), builds 32-bit MIPS words
//  with the opcodes the decoder recognises, and writes them sequentially into instruction memory.
//  It sits between the self-test/boot sequencer and the instruction memory write port.
//  It is used to load programs before the core is released from reset.
// PARAMETERS
//  ADDR_W     8    word-address width of the memory write port
//  DEPTH      256  max words loaded before full; 1 <= DEPTH <= 2**ADDR_W
//  BASE_ADDR  0    word address of the first write; addresses wrap mod 2**ADDR_W
// PORTS
//  clk         in   1         clock; all state updates on the rising edge
//  reset       in   1         synchronous, active-high reset
//  req_valid   in   1         encode request present
//  req_ready   out  1         loader can accept; combinational = !reset & !flush & !full
//  req_kind    in   4         class: 0 RTYPE,1 LD,2 LW,3 LBU,4 LB,5 SD,6 SW,7 SB,8 BEQ,9 BNE,10 J,11 ADDI,12 ANDI,13 ORI,14 SLTI,15 DADDI
//  req_rs      in   5         rs field
//  req_rt      in   5         rt field
//  req_rd      in   5         rd field (RTYPE only)
//  req_shamt   in   5         shamt field (RTYPE only)
//  req_funct   in   6         funct field (RTYPE only)
//  req_imm     in   16        immediate/offset (I-type only)
//  req_target  in   26        jump target (J only)
//  flush       in   1         restart loading at BASE_ADDR; clears count, full, err
//  mem_we      out  1         one-cycle write strobe
//  mem_addr    out  ADDR_W    write word address
//  mem_wdata   out  32        encoded instruction word
//  count       out  ADDR_W+1  number of words accepted since reset/flush
//  full        out  1         count == DEPTH
//  err         out  1         sticky: req_valid seen while full
// BEHAVIOUR
//  - Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0. Reset dominates every other input.
//  - Opcodes: RTYPE 000000, LD 110111, LW 100011, LBU 100100, LB 100000, SD 111111, SW 101011, SB 101000,
//    BEQ 000100, BNE 000101, J 000010, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, DADDI 011000.
//  - Encoding formats:
//    RTYPE = {op, rs, rt, rd, shamt, funct}. J = {op, target}. All other classes = {op, rs, rt, imm}.
//  - Fields not used by the selected format are ignored.
//  - Accept: when req_valid & req_ready at edge N, then on cycle N+1 mem_we=1, mem_addr=(BASE_ADDR+count_N) mod 2**ADDR_W,
//    and mem_wdata=encoded word. count increments at the same edge.
//  - Latency is 1 cycle. Throughput is 1 word/cycle; back-to-back accepts give consecutive addresses.
//  - mem_we is low in any cycle that does not follow an accept. mem_addr and mem_wdata hold their last values while mem_we is low.
//  - State machine (from count):
//      IDLE   count=0            -> LOAD on accept
//      LOAD   0 < count < DEPTH  -> FULL when the accept makes count = DEPTH
//      FULL   count=DEPTH        -> req_ready=0; exits only via flush or reset
//  - full is registered. With DEPTH=1, full=1 in the cycle after the single accept.
//  - err: set at the edge where req_valid=1 and full=1. Held until flush or reset.
//    A request blocked while full is not consumed; the requester keeps it pending.
//  - Flush: req_ready=0 during the flush cycle, so no accept happens. count, full and err clear at that edge.
//    The next accept writes BASE_ADDR.
//  - A write registered at the edge before flush is still emitted (mem_we=1) during the flush cycle.
//  - Reset mid-operation: a write registered in the prior cycle is dropped. mem_we=0 in the cycle after reset is sampled.
//  - flush and reset together: reset behaviour applies.
// TESTING
//  1. After reset, ADDI rs=1 rt=2 imm=0x0005 -> next cycle mem_we=1, addr=0x00, wdata=0x20220005; count=1.
//  2. Back-to-back RTYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20, then J target=0x0000010, then SW rs=29 rt=31 imm=0xFFFC
//     -> wdata 0x00221820 @0, 0x08000010 @1, 0xAFBFFFFC @2 on consecutive cycles.
//  3. DEPTH=4: five requests, valid held continuously -> four writes at 0..3, full=1, req_ready=0, err=1, no fifth mem_we.
//  4. BASE_ADDR=0xFE, ADDR_W=8: three accepts -> addresses 0xFE, 0xFF, 0x00.
//  5. count=3, pulse flush while req_valid=1 -> no accept that cycle, count=0, err=0; the next accept writes BASE_ADDR.
//  6. Assert reset the cycle after an accept -> mem_we=0 the following cycle, and all outputs return to reset values.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: turns encode requests into 32-bit MIPS words and
// writes them to consecutive instruction-memory word addresses starting at BASE_ADDR.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | nothing loaded since reset/flush (count = 0)
//  LOAD   | some words loaded, room left (0 < count < DEPTH)
//  FULL   | DEPTH words loaded; requests blocked until flush or reset
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              flush,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    localparam logic [3:0] K_RTYPE = 4'd0;
    localparam logic [3:0] K_J     = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_inc;
    logic              accept;
    logic [5:0]        opcode;
    logic [31:0]       enc_word;

    assign count_inc = count_q + {{ADDR_W{1'b0}}, 1'b1};
    assign accept    = req_valid & req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush always restarts; an accept reaching DEPTH parks in FULL
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = (count_inc == DEPTH_C) ? S_FULL : S_LOAD;
        end
    end

    // Outputs decoded from state; ready also drops combinationally on reset/flush
    always_comb begin
        req_ready = 1'b0;
        full      = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: req_ready = ~reset & ~flush;
            S_FULL:         full      = 1'b1;
            default: begin
                req_ready = 1'b0;
                full      = 1'b0;
            end
        endcase
    end

    // Opcode lookup and format selection for the requested instruction class
    always_comb begin
        case (req_kind)
            4'd0:    opcode = 6'b000000;
            4'd1:    opcode = 6'b110111;
            4'd2:    opcode = 6'b100011;
            4'd3:    opcode = 6'b100100;
            4'd4:    opcode = 6'b100000;
            4'd5:    opcode = 6'b111111;
            4'd6:    opcode = 6'b101011;
            4'd7:    opcode = 6'b101000;
            4'd8:    opcode = 6'b000100;
            4'd9:    opcode = 6'b000101;
            4'd10:   opcode = 6'b000010;
            4'd11:   opcode = 6'b001000;
            4'd12:   opcode = 6'b001100;
            4'd13:   opcode = 6'b001101;
            4'd14:   opcode = 6'b001010;
            default: opcode = 6'b011000;
        endcase
        if (req_kind == K_RTYPE) begin
            enc_word = {opcode, req_rs, req_rt, req_rd, req_shamt, req_funct};
        end else if (req_kind == K_J) begin
            enc_word = {opcode, req_target};
        end else begin
            enc_word = {opcode, req_rs, req_rt, req_imm};
        end
    end

    // Write port, word counter and sticky overflow flag; address/data hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_C;
            mem_wdata <= 32'd0;
            count_q   <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= accept;
            if (accept) begin
                mem_addr  <= BASE_C + count_q[ADDR_W-1:0];
                mem_wdata <= enc_word;
                count_q   <= count_inc;
            end
            if (flush) begin
                count_q <= '0;
                err     <= 1'b0;
            end else if (req_valid && full) begin
                err <= 1'b1;
            end
        end
    end

    assign count = count_q;

endmodule
